// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the shift-register serializer/deserializer family.
package shift_reg_pkg;

    localparam int unsigned REG_WIDTH = 4;

    localparam logic SR_DIR_RIGHT = 1'b1;
    localparam logic SR_DIR_LEFT  = 1'b0;

    typedef enum logic [1:0] {
        SR_IDLE,
        SR_SHIFT,
        SR_DONE
    } sr_state_t;

endpackage

// File: rtl/sr_bit_counter.sv
// Bit counter with clear, load and terminal-count flag; saturates at TC_VAL, never wraps.
module sr_bit_counter #(
    parameter int unsigned CW     = 3,
    parameter int unsigned TC_VAL = 3
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(TC_VAL));

endmodule

// File: rtl/shift_reg_serializer.sv
// Parallel-to-serial feeder for the 4-bit left/right shift register.
// Optional trailing even-parity bit: define SERIALIZER_PARITY_EN.
module shift_reg_serializer
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH    = REG_WIDTH,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_dir,
    input  logic             abort,
    output logic             ser_out,
    output logic             dir_out,
    output logic             busy,
    output logic             frame_done
);

`ifdef SERIALIZER_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CW = $clog2(FRAME_LEN + 1);

    sr_state_t            state, state_d;
    logic [FRAME_LEN-1:0] frame, frame_d;
    logic                 accept;
    logic [CW-1:0]        cnt;
    logic                 tc;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic                 ser_d, dir_d, ready_d, busy_d, done_d;

    // Frame is stored in transmit order: MSB of the vector is the next bit on the wire.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [WIDTH-1:0] data,
                                                         input logic             dir);
        logic [FRAME_LEN-1:0] f;
        f = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (dir == SR_DIR_RIGHT)
                f[FRAME_LEN-1-i] = data[WIDTH-1-i];
            else
                f[FRAME_LEN-1-i] = data[i];
        end
`ifdef SERIALIZER_PARITY_EN
        f[0] = ^data;
`endif
        return f;
    endfunction

    assign accept = (state == SR_IDLE) && load_valid && !abort;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SR_IDLE;
            frame      <= '0;
            ser_out    <= IDLE_BIT;
            dir_out    <= SR_DIR_LEFT;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            frame      <= frame_d;
            ser_out    <= ser_d;
            dir_out    <= dir_d;
            load_ready <= ready_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            SR_IDLE:  if (accept) state_d = SR_SHIFT;
            SR_SHIFT: begin
                if (abort)   state_d = SR_IDLE;
                else if (tc) state_d = SR_DONE;
            end
            SR_DONE:  state_d = SR_IDLE;
            default:  state_d = SR_IDLE;
        endcase
    end

    // Outputs are computed from the next state so that every output is a flop.
    always_comb begin
        frame_d = frame;
        if (accept)
            frame_d = build_frame(load_data, load_dir);
        else if (state == SR_SHIFT)
            frame_d = frame << 1;

        ser_d   = (state_d == SR_SHIFT) ? frame_d[FRAME_LEN-1] : IDLE_BIT;
        dir_d   = accept ? load_dir : dir_out;
        ready_d = (state_d == SR_IDLE);
        busy_d  = (state_d != SR_IDLE);
        done_d  = (state_d == SR_DONE);
    end

    assign cnt_clr = (state_d != SR_SHIFT);
    assign cnt_en  = (state == SR_SHIFT);

    sr_bit_counter #(
        .CW     (CW),
        .TC_VAL (FRAME_LEN - 1)
    ) u_cnt (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (accept),
        .load_val ('0),
        .en       (cnt_en),
        .cnt      (cnt),
        .tc       (tc)
    );

endmodule
